// File: rtl/morse_pkg.sv
// Shared types and duration tables for the Morse tone player.
// All durations are counted in 10 ms ticks produced by morse_tick_gen.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2,
    LGAP = 2'd3
  } state_t;

  localparam int MAX_ELEMS = 6;

  localparam logic [7:0] DOT_SHORT  = 8'd20;
  localparam logic [7:0] DOT_MED    = 8'd50;
  localparam logic [7:0] DOT_LONG   = 8'd80;
  localparam logic [7:0] DASH_SHORT = 8'd100;
  localparam logic [7:0] DASH_MED   = 8'd150;
  localparam logic [7:0] DASH_LONG  = 8'd200;
  localparam logic [7:0] GAP_SHORT  = 8'd50;
  localparam logic [7:0] GAP_LONG   = 8'd100;
  localparam logic [7:0] LGAP_SHORT = 8'd100;
  localparam logic [7:0] LGAP_LONG  = 8'd200;

  // Code 00 falls back to the shortest setting for both dot and dash.
  function automatic logic [7:0] dot_ticks(input logic [1:0] sel);
    case (sel)
      2'b10:   dot_ticks = DOT_MED;
      2'b11:   dot_ticks = DOT_LONG;
      default: dot_ticks = DOT_SHORT;
    endcase
  endfunction

  function automatic logic [7:0] dash_ticks(input logic [1:0] sel);
    case (sel)
      2'b10:   dash_ticks = DASH_MED;
      2'b11:   dash_ticks = DASH_LONG;
      default: dash_ticks = DASH_SHORT;
    endcase
  endfunction

  function automatic logic [7:0] gap_ticks(input logic sel);
    gap_ticks = sel ? GAP_LONG : GAP_SHORT;
  endfunction

  function automatic logic [7:0] lgap_ticks(input logic sel);
    lgap_ticks = sel ? LGAP_LONG : LGAP_SHORT;
  endfunction

  function automatic logic [2:0] eff_len(input logic [2:0] len);
    eff_len = (int'(len) > MAX_ELEMS) ? 3'(MAX_ELEMS) : len;
  endfunction

endpackage

// File: rtl/morse_tone_player_if.sv
// Character handshake between the encoder front end and the tone player.
// valid/ready: a character transfers on a rising clk edge where sym_valid && sym_ready; the master holds sym_len/sym_bits stable while sym_valid is high and not yet accepted.
interface morse_tone_player_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [2:0] sym_len;
  logic [5:0] sym_bits;

  modport master (output sym_valid, output sym_len, output sym_bits, input sym_ready);
  modport slave  (input sym_valid, input sym_len, input sym_bits, output sym_ready);
endinterface

// File: rtl/morse_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// with a synchronous clear so every state begins on a fresh tick period.
module morse_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/morse_tone_player.sv
// Plays one Morse character per handshake as timed tones and silences.
// Define MORSE_PLAYER_TONE_EN for a TONE_DIV square wave (passive piezo); otherwise buzzer is steady high in TONE.
module morse_tone_player
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int TONE_DIV = 50_000
) (
  input  logic                clk,
  input  logic                rst,
  morse_tone_player_if.slave  sym,
  input  logic [1:0]          sel_dot,
  input  logic [1:0]          sel_dash,
  input  logic                sel_gap,
  input  logic                sel_lgap,
  output logic                buzzer,
  output logic                busy,
  output state_t              dbg_state
);

  state_t     state;
  logic [2:0] len_q;
  logic [2:0] idx;
  logic [5:0] bits_q;
  logic [1:0] dot_q;
  logic [1:0] dash_q;
  logic       gap_q;
  logic       lgap_q;
  logic [7:0] dcnt;
  logic [7:0] dur;
  logic       tick;
  logic       done;
  logic       xfer;
  logic       clr;
  logic [2:0] new_len;

  assign sym.sym_ready = (state == IDLE) && !rst;
  assign busy          = (state != IDLE) && !rst;
  assign dbg_state     = state;
  assign xfer          = sym.sym_valid && sym.sym_ready;
  assign new_len       = eff_len(sym.sym_len);

  always_comb begin
    dur = 8'd1;
    case (state)
      TONE:    dur = bits_q[idx] ? dash_ticks(dash_q) : dot_ticks(dot_q);
      GAP:     dur = gap_ticks(gap_q);
      LGAP:    dur = lgap_ticks(lgap_q);
      default: dur = 8'd1;
    endcase
  end

  assign done = tick && (dcnt == dur - 8'd1);
  // Holding the prescaler clear in IDLE and on every exit restarts it at each state entry.
  assign clr  = (state == IDLE) || done;

  morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

`ifdef MORSE_PLAYER_TONE_EN
  localparam int PW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  logic [PW-1:0] pcnt;
  logic          phase;
`else
  logic unused_tone_div;
  assign unused_tone_div = (TONE_DIV > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      idx    <= '0;
      bits_q <= '0;
      dot_q  <= '0;
      dash_q <= '0;
      gap_q  <= 1'b0;
      lgap_q <= 1'b0;
      dcnt   <= '0;
      buzzer <= 1'b0;
`ifdef MORSE_PLAYER_TONE_EN
      pcnt   <= '0;
      phase  <= 1'b0;
`endif
    end else begin
`ifdef MORSE_PLAYER_TONE_EN
      buzzer <= (state == TONE) && phase;
      // Outside TONE the phase sits at its entry value so each element starts high.
      if (state == TONE) begin
        if (pcnt == PW'(TONE_DIV - 1)) begin
          pcnt  <= '0;
          phase <= ~phase;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end else begin
        pcnt  <= '0;
        phase <= 1'b1;
      end
`else
      buzzer <= (state == TONE);
`endif

      if (state == IDLE || done) dcnt <= '0;
      else if (tick)             dcnt <= dcnt + 8'd1;

      case (state)
        IDLE: begin
          if (xfer) begin
            len_q  <= new_len;
            bits_q <= sym.sym_bits;
            dot_q  <= sel_dot;
            dash_q <= sel_dash;
            gap_q  <= sel_gap;
            lgap_q <= sel_lgap;
            idx    <= '0;
            state  <= (new_len == 3'd0) ? LGAP : TONE;
          end
        end
        TONE: begin
          if (done) state <= (idx < len_q - 3'd1) ? GAP : LGAP;
        end
        GAP: begin
          if (done) begin
            idx   <= idx + 3'd1;
            state <= TONE;
          end
        end
        LGAP: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
